key_click_decoder: RTL and testbench
====================================

KEY_CLICK_DECODER -- requirements
Module: key_click_decoder

Interface
REQ-001 Parameter CNT_DBL_MAX, default 20'd50, SHALL set the double-click window in clock cycles, measured from detected release.
REQ-002 Parameter CNT_LONG_MAX, default 20'd100, SHALL set the long-press hold threshold in clock cycles, measured from the accepted press; both defaults are simulation-scaled.
REQ-003 sys_clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 sys_rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 key_flag  input  1  SHALL be the one-cycle debounced-press pulse from the upstream debounce filter.
REQ-006 key_in  input  1  SHALL be the raw key level: 0 = pressed, 1 = released.
REQ-007 single_flag  output  1  SHALL pulse high one cycle per classified single click.
REQ-008 double_flag  output  1  SHALL pulse high one cycle per classified double click.
REQ-009 long_flag  output  1  SHALL pulse high one cycle per classified long press.

Function
REQ-010 FSM states SHALL be IDLE, HOLD1, GAP, HOLD2 and LONG.
REQ-011 In IDLE, key_flag=1 SHALL move to HOLD1 and clear the counter.
REQ-012 In HOLD1, each cycle with key_in=0 SHALL increment the counter; when the counter equals CNT_LONG_MAX-1, the FSM SHALL assert long_flag on the next edge and go to LONG.
REQ-013 In HOLD1, key_in=1 SHALL move to GAP and clear the counter; release takes priority over the long threshold on the same cycle.
REQ-014 In GAP, the counter SHALL increment each cycle; key_flag=1 SHALL assert double_flag on the next edge and go to HOLD2.
REQ-015 In GAP, when the counter equals CNT_DBL_MAX-1 and key_flag=0, the FSM SHALL assert single_flag on the next edge and return to IDLE.
REQ-016 If key_flag=1 in GAP on the same cycle the counter reaches CNT_DBL_MAX-1, double_flag SHALL win and single_flag SHALL NOT pulse.
REQ-017 HOLD2 and LONG SHALL return to IDLE on the first cycle with key_in=1, with no output pulse; their counter SHALL stay cleared.
REQ-018 key_flag SHALL be ignored in HOLD1, HOLD2 and LONG; a third click while in HOLD2 SHALL produce nothing.
REQ-019 Exactly one of single_flag, double_flag or long_flag SHALL pulse per gesture, each for exactly one cycle; at most one output is high in any cycle.
REQ-020 All outputs SHALL be registered; each pulse appears one clock after its triggering condition.
REQ-021 The counter SHALL be 20 bits wide and SHALL never wrap: every state leaves before the counter exceeds its threshold.

Reset
REQ-022 sys_rst_n=0 SHALL immediately force state IDLE, counter 0, and all three outputs 0, regardless of clock.
REQ-023 Reset mid-gesture SHALL discard the gesture; after release of reset, a key still held SHALL produce no output until a new key_flag arrives.

Structure
REQ-024 State encodings SHALL be module-local localparams; no shared package is required.
REQ-025 The block SHALL be a single module with no sub-modules; one counter SHALL be shared between the hold and gap measurements.

Verification
REQ-026 Single click: key_flag pulse at t0, key_in=1 from t0+10 -> single_flag high exactly at t0+10+50 (±1 per REQ-020); no other pulse.
REQ-027 Double click: flag at t0, release at t0+10, second flag at t0+30, release at t0+40 -> double_flag one cycle after t0+30; no single_flag.
REQ-028 Long press: flag at t0, key_in held 0 for 150 cycles -> long_flag one cycle after the counter reaches 99; nothing at release; FSM back in IDLE.
REQ-029 Window boundary: second flag on the exact cycle the gap counter reaches 49 -> double_flag only.
REQ-030 Reset mid-GAP: assert sys_rst_n=0 asynchronously 20 cycles into GAP -> outputs 0 at once; no pulse after deassertion.
REQ-031 Ignored flags: key_flag pulses during HOLD2 and LONG -> no outputs, and correct IDLE return on release.

Source files
------------

// File: rtl/key_click_decoder.sv
// Classifies debounced key gestures into single click, double click or long press.
// One shared 20-bit counter times both the press hold and the release gap.
module key_click_decoder #(
  parameter logic [19:0] CNT_DBL_MAX  = 20'd50,
  parameter logic [19:0] CNT_LONG_MAX = 20'd100
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_flag,
  input  logic key_in,
  output logic single_flag,
  output logic double_flag,
  output logic long_flag
);

  // state | meaning
  // IDLE  | waiting for a debounced press
  // HOLD1 | first press held, timing toward long-press threshold
  // GAP   | first press released, timing the double-click window
  // HOLD2 | second press held, waiting for release
  // LONG  | long press reported, waiting for release
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] HOLD1 = 3'd1;
  localparam logic [2:0] GAP   = 3'd2;
  localparam logic [2:0] HOLD2 = 3'd3;
  localparam logic [2:0] LONG  = 3'd4;

  localparam logic [19:0] LONG_LAST = CNT_LONG_MAX - 20'd1;
  localparam logic [19:0] DBL_LAST  = CNT_DBL_MAX - 20'd1;

  logic [2:0]  state;
  logic [19:0] cnt;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      cnt         <= 20'd0;
      single_flag <= 1'b0;
      double_flag <= 1'b0;
      long_flag   <= 1'b0;
    end else begin
      single_flag <= 1'b0;
      double_flag <= 1'b0;
      long_flag   <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= 20'd0;
          if (key_flag) state <= HOLD1;
        end
        HOLD1: begin
          // release wins over the long threshold on the same cycle
          if (key_in) begin
            state <= GAP;
            cnt   <= 20'd0;
          end else if (cnt == LONG_LAST) begin
            state     <= LONG;
            cnt       <= 20'd0;
            long_flag <= 1'b1;
          end else begin
            cnt <= cnt + 20'd1;
          end
        end
        GAP: begin
          // a second press on the last window cycle still counts as a double
          if (key_flag) begin
            state       <= HOLD2;
            cnt         <= 20'd0;
            double_flag <= 1'b1;
          end else if (cnt == DBL_LAST) begin
            state       <= IDLE;
            cnt         <= 20'd0;
            single_flag <= 1'b1;
          end else begin
            cnt <= cnt + 20'd1;
          end
        end
        HOLD2, LONG: begin
          cnt <= 20'd0;
          if (key_in) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= 20'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_click_decoder.sv
// Directed bench for key_click_decoder: gesture table plus reset corner sequences.
module tb_key_click_decoder;

  logic sys_clk;
  logic sys_rst_n;
  logic key_flag;
  logic key_in;
  logic single_flag;
  logic double_flag;
  logic long_flag;

  int total = 0;
  int bad   = 0;

  localparam int GEST_EDGES = 200;

  key_click_decoder dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .key_flag    (key_flag),
    .key_in      (key_in),
    .single_flag (single_flag),
    .double_flag (double_flag),
    .long_flag   (long_flag)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // kind: 0 none, 1 single, 2 double, 3 long; edges counted from the first key_flag edge
  typedef struct {
    string name;
    int    rel1;
    int    flag2;
    int    rel2;
    int    flag3;
    int    kind;
    int    exp_edge;
    int    exp_cnt;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v, input int n);
    key_flag = (n == 0) || (n == v.flag2) || (n == v.flag3);
    key_in   = !((n < v.rel1) || (v.flag2 >= 0 && n >= v.flag2 && n < v.rel2));
  endtask

  task automatic run_gesture(input vec_t v);
    int first_kind;
    int first_edge;
    int pulses;
    int multi;
    int k;
    first_kind = 0;
    first_edge = -1;
    pulses     = 0;
    multi      = 0;
    drive(v, 0);
    for (int n = 0; n < GEST_EDGES; n++) begin
      @(posedge sys_clk);
      #1;
      k = int'(single_flag) + int'(double_flag) + int'(long_flag);
      if (k > 1) multi = 1;
      if (k > 0) begin
        pulses++;
        if (first_kind == 0) begin
          first_kind = single_flag ? 1 : (double_flag ? 2 : 3);
          first_edge = n;
        end
      end
      drive(v, n + 1);
    end
    key_flag = 1'b0;
    key_in   = 1'b1;
    check({v.name, " kind"},   first_kind, v.kind);
    check({v.name, " edge"},   first_edge, v.exp_edge);
    check({v.name, " pulses"}, pulses,     v.exp_cnt);
    check({v.name, " onehot"}, multi,      0);
  endtask

  task automatic count_pulses(input int edges, output int p);
    p = 0;
    for (int n = 0; n < edges; n++) begin
      @(posedge sys_clk);
      #1;
      if (single_flag || double_flag || long_flag) p++;
    end
  endtask

  initial begin
    int p;

    vecs[0] = '{"single",        10, -1,  0,  -1, 1,  60, 1};
    vecs[1] = '{"double",        10, 30, 40,  -1, 2,  30, 1};
    vecs[2] = '{"dbl_boundary",  10, 60, 70,  -1, 2,  60, 1};
    vecs[3] = '{"dbl_late",      10, 61, 70,  -1, 1,  60, 2};
    vecs[4] = '{"long",         150, -1,  0,  -1, 3, 100, 1};
    vecs[5] = '{"long_rel_prio",100, -1,  0,  -1, 1, 150, 1};
    vecs[6] = '{"long_just",    101, -1,  0,  -1, 3, 100, 1};
    vecs[7] = '{"third_click",   10, 20, 40,  30, 2,  20, 1};
    vecs[8] = '{"flag_in_long", 150, -1,  0, 120, 3, 100, 1};
    vecs[9] = '{"flag_in_hold1", 10, -1,  0,   5, 1,  60, 1};

    sys_rst_n = 1'b0;
    key_flag  = 1'b0;
    key_in    = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst single", int'(single_flag), 0);
    check("rst double", int'(double_flag), 0);
    check("rst long",   int'(long_flag),   0);
    sys_rst_n = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1;

    foreach (vecs[i]) begin
      run_gesture(vecs[i]);
      repeat (5) @(posedge sys_clk);
      #1;
    end

    // reset 20 cycles into GAP with the key pressed again: gesture discarded
    key_flag = 1'b1;
    key_in   = 1'b0;
    @(posedge sys_clk);
    #1;
    key_flag = 1'b0;
    repeat (9) @(posedge sys_clk);
    #1;
    key_in = 1'b1;
    repeat (21) @(posedge sys_clk);
    #3;
    key_in    = 1'b0;
    sys_rst_n = 1'b0;
    #1;
    check("mid_gap rst outputs", int'(single_flag | double_flag | long_flag), 0);
    repeat (3) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    count_pulses(120, p);
    check("mid_gap held after rst", p, 0);
    key_in = 1'b1;
    count_pulses(80, p);
    check("mid_gap released after rst", p, 0);

    // async reset clears a pulse that is already high
    key_flag = 1'b1;
    key_in   = 1'b0;
    @(posedge sys_clk);
    #1;
    key_flag = 1'b0;
    repeat (100) @(posedge sys_clk);
    #1;
    check("async pre long", int'(long_flag), 1);
    #1;
    sys_rst_n = 1'b0;
    #1;
    check("async drop long", int'(long_flag), 0);
    key_in = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    count_pulses(70, p);
    check("async after rst quiet", p, 0);

    run_gesture(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
